noise_channel_gen2: RTL and testbench
=====================================

NOISE_CHANNEL_GEN2 -- requirements
Module: noise_channel_gen2

Interface
REQ-001 The block SHALL have parameter LFSR_WIDTH, default 15, meaning LFSR length in bits (minimum 8).
REQ-002 The block SHALL have parameter SHORT_TAP, default 6, meaning the feedback tap index used in short mode (1 to LFSR_WIDTH-1).
REQ-003 The block SHALL have parameter PERIOD_WIDTH, default 12, meaning the timer reload width.
REQ-004 The block SHALL have parameter OUT_WIDTH, default 9, meaning output sample width (minimum 4).
REQ-005 i_clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_tick_stb  in  1  one-cycle frame tick that clocks the envelope and length logic.
REQ-008 i_trigger  in  1  one-cycle strobe that captures all i_cfg_* inputs and (re)starts the note.
REQ-009 i_cfg_period  in  PERIOD_WIDTH  timer reload value; LFSR steps every i_cfg_period+1 clocks.
REQ-010 i_cfg_mode  in  1  0 = long mode (tap 1), 1 = short mode (tap SHORT_TAP).
REQ-011 i_cfg_volume  in  4  initial volume, or constant volume when decay is off.
REQ-012 i_cfg_decay_en  in  1  1 = volume decays; 0 = constant volume.
REQ-013 i_cfg_decay_div  in  4  envelope divider reload; one volume step per i_cfg_decay_div+1 ticks.
REQ-014 i_cfg_length  in  8  note length in ticks (used only with the macro in REQ-036).
REQ-015 o_output  out  OUT_WIDTH  audio sample.
REQ-016 o_active  out  1  high while the FSM is in RUN.
REQ-017 o_lfsr_stb  out  1  one-cycle pulse on each LFSR step.

Function
REQ-018 The FSM SHALL have two states, IDLE and RUN: i_trigger moves it to RUN from either state; length expiry (REQ-036) moves it to IDLE; no other transitions exist.
REQ-019 On i_trigger, the block SHALL latch all configuration inputs, load the timer with i_cfg_period, load volume with i_cfg_volume, and load the envelope divider with i_cfg_decay_div; changes take effect on the following clock.
REQ-020 In RUN, the timer SHALL decrement each clock; at zero it SHALL reload the latched period and step the LFSR, with o_lfsr_stb high for that one cycle.
REQ-021 The LFSR step SHALL be a right shift with new MSB = lfsr[0] XOR lfsr[tap], where tap = 1 in long mode and SHORT_TAP in short mode.
REQ-022 The LFSR SHALL retain its state across i_trigger and across IDLE; it SHALL NOT be reseeded except by reset.
REQ-023 With period 0, the LFSR SHALL step every clock.
REQ-024 When decay is on in RUN, each i_tick_stb SHALL decrement the divider; at zero the divider SHALL reload and the volume SHALL decrement, saturating at 0 (no wrap, no loop).
REQ-025 When decay is off, the volume SHALL hold the latched i_cfg_volume.
REQ-026 o_output SHALL equal volume << (OUT_WIDTH-4) when o_active=1 and lfsr[0]=0; otherwise it SHALL be 0. The output is registered with one clock of latency.
REQ-027 If i_trigger and i_tick_stb arrive in the same cycle, i_trigger SHALL win and the tick SHALL be ignored.
REQ-028 If i_trigger and a timer expiry arrive in the same cycle, the LFSR SHALL step and the timer SHALL load the new period.
REQ-029 In IDLE, the timer and envelope SHALL be frozen, and o_lfsr_stb and o_output SHALL be 0.

Reset
REQ-030 Asserting i_rst_n low SHALL immediately set: FSM to IDLE, LFSR to 1, timer to 0, volume to 0, divider to 0, length to 0, and all latched configuration to 0.
REQ-031 During reset, o_output, o_active and o_lfsr_stb SHALL be 0.
REQ-032 Reset asserted mid-note SHALL abort the note; after release the block SHALL stay IDLE until i_trigger.
REQ-033 Reset release SHALL be synchronised externally; the block adds no deassertion logic.

Configuration
REQ-034 Macro NOISE_LENGTH_COUNTER_EN SHALL control the length counter.
REQ-035 Without the macro, i_cfg_length SHALL be ignored and RUN SHALL persist until reset.
REQ-036 With the macro, i_trigger SHALL load the length from i_cfg_length; each accepted tick in RUN SHALL decrement it; reaching 0 SHALL move the FSM to IDLE on that clock; a length of 0 at trigger SHALL go to IDLE on the first tick.

Verification
REQ-037 Reset, then trigger with period=0, long mode -> o_lfsr_stb every clock; LFSR goes 0x0001 -> 0x4000 -> 0x2000; 32767-step cycle returns to 0x0001.
REQ-038 Short mode, SHORT_TAP=6, period=0 -> sequence repeats with period 93 (or 31 from some seeds); o_lfsr_stb spacing is 1.
REQ-039 period=3 -> o_lfsr_stb exactly every 4 clocks; o_output is 0 or volume<<5 only.
REQ-040 volume=15, decay on, div=1 -> volume decrements every 2 ticks and reaches 0 after 30 ticks, then holds at 0.
REQ-041 Macro on, length=3 -> o_active drops on the 3rd tick; trigger coincident with a tick -> length reloads and the tick is ignored.
REQ-042 Reset pulse mid-note -> all outputs 0 immediately; IDLE until the next i_trigger.

Source files
------------

// File: rtl/noise_channel_gen2.sv
// Noise channel: LFSR noise source stepped by a programmable timer, with a
// 4-bit decaying volume envelope and a registered audio sample output.
// Optional length counter enabled by defining NOISE_LENGTH_COUNTER_EN; without
// it a triggered note runs until reset.
module noise_channel_gen2 #(
   parameter int unsigned LFSR_WIDTH   = 15,
   parameter int unsigned SHORT_TAP    = 6,
   parameter int unsigned PERIOD_WIDTH = 12,
   parameter int unsigned OUT_WIDTH    = 9
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_tick_stb,
   input  logic                    i_trigger,
   input  logic [PERIOD_WIDTH-1:0] i_cfg_period,
   input  logic                    i_cfg_mode,
   input  logic [3:0]              i_cfg_volume,
   input  logic                    i_cfg_decay_en,
   input  logic [3:0]              i_cfg_decay_div,
   input  logic [7:0]              i_cfg_length,
   output logic [OUT_WIDTH-1:0]    o_output,
   output logic                    o_active,
   output logic                    o_lfsr_stb
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                  state_q, state_d;
   logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
   logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    mode_q, mode_d;
   logic                    decay_en_q, decay_en_d;
   logic [3:0]              div_reload_q, div_reload_d;
   logic [3:0]              div_q, div_d;
   logic [3:0]              volume_q, volume_d;
   logic [OUT_WIDTH-1:0]    out_q, out_d;
   logic                    run;
   logic                    expire;
   logic                    tap_bit;

`ifdef NOISE_LENGTH_COUNTER_EN
   logic [7:0]              length_q, length_d;
`else
   logic                    unused_cfg_length;
   assign unused_cfg_length = ^i_cfg_length;
`endif

   assign run     = (state_q == StRun);
   assign expire  = run && (timer_q == '0);
   // Tap uses the mode latched for the current note, even on a re-trigger edge.
   assign tap_bit = mode_q ? lfsr_q[SHORT_TAP] : lfsr_q[1];

   // Next-state: trigger capture, timer/LFSR stepping, envelope and length
   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      timer_d      = timer_q;
      period_d     = period_q;
      mode_d       = mode_q;
      decay_en_d   = decay_en_q;
      div_reload_d = div_reload_q;
      div_d        = div_q;
      volume_d     = volume_q;
`ifdef NOISE_LENGTH_COUNTER_EN
      length_d     = length_q;
`endif

      // An expiry steps the LFSR even when a trigger lands on the same clock
      if (expire) begin
         lfsr_d = {lfsr_q[0] ^ tap_bit, lfsr_q[LFSR_WIDTH-1:1]};
      end

      if (i_trigger) begin
         state_d      = StRun;
         period_d     = i_cfg_period;
         mode_d       = i_cfg_mode;
         decay_en_d   = i_cfg_decay_en;
         div_reload_d = i_cfg_decay_div;
         timer_d      = i_cfg_period;
         volume_d     = i_cfg_volume;
         div_d        = i_cfg_decay_div;
`ifdef NOISE_LENGTH_COUNTER_EN
         length_d     = i_cfg_length;
`endif
      end else if (run) begin
         timer_d = expire ? period_q : timer_q - PERIOD_WIDTH'(1);
         if (i_tick_stb && decay_en_q) begin
            if (div_q == '0) begin
               div_d = div_reload_q;
               if (volume_q != '0) begin
                  volume_d = volume_q - 4'd1;
               end
            end else begin
               div_d = div_q - 4'd1;
            end
         end
`ifdef NOISE_LENGTH_COUNTER_EN
         // A zero length stops on the first tick rather than wrapping
         if (i_tick_stb) begin
            if (length_q <= 8'd1) begin
               state_d  = StIdle;
               length_d = '0;
            end else begin
               length_d = length_q - 8'd1;
            end
         end
`endif
      end

      // Sample is gated off on the clock the note ends so IDLE always reads 0
      out_d = '0;
      if (run && (state_d == StRun) && !lfsr_q[0]) begin
         out_d = OUT_WIDTH'(volume_q) << (OUT_WIDTH - 4);
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         lfsr_q       <= LFSR_WIDTH'(1);
         timer_q      <= '0;
         period_q     <= '0;
         mode_q       <= 1'b0;
         decay_en_q   <= 1'b0;
         div_reload_q <= '0;
         div_q        <= '0;
         volume_q     <= '0;
         out_q        <= '0;
`ifdef NOISE_LENGTH_COUNTER_EN
         length_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         timer_q      <= timer_d;
         period_q     <= period_d;
         mode_q       <= mode_d;
         decay_en_q   <= decay_en_d;
         div_reload_q <= div_reload_d;
         div_q        <= div_d;
         volume_q     <= volume_d;
         out_q        <= out_d;
`ifdef NOISE_LENGTH_COUNTER_EN
         length_q     <= length_d;
`endif
      end
   end

   assign o_output   = out_q;
   assign o_active   = run;
   assign o_lfsr_stb = expire;

endmodule

// File: tb/tb_noise_channel_gen2.sv
// Self-checking bench for noise_channel_gen2: directed vector table plus
// hand-written sequences for reset, long LFSR cycle, decay and length.
module tb_noise_channel_gen2;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_tick_stb;
   logic        i_trigger;
   logic [11:0] i_cfg_period;
   logic        i_cfg_mode;
   logic [3:0]  i_cfg_volume;
   logic        i_cfg_decay_en;
   logic [3:0]  i_cfg_decay_div;
   logic [7:0]  i_cfg_length;
   logic [8:0]  o_output;
   logic        o_active;
   logic        o_lfsr_stb;

   int n_cmp = 0;
   int n_err = 0;

   noise_channel_gen2 dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_tick_stb     (i_tick_stb),
      .i_trigger      (i_trigger),
      .i_cfg_period   (i_cfg_period),
      .i_cfg_mode     (i_cfg_mode),
      .i_cfg_volume   (i_cfg_volume),
      .i_cfg_decay_en (i_cfg_decay_en),
      .i_cfg_decay_div(i_cfg_decay_div),
      .i_cfg_length   (i_cfg_length),
      .o_output       (o_output),
      .o_active       (o_active),
      .o_lfsr_stb     (o_lfsr_stb)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        trig;
      logic        tick;
      logic [11:0] period;
      logic        mode;
      logic [3:0]  vol;
      logic        dec;
      logic [3:0]  div;
      logic        a;
      logic        s;
      logic [8:0]  o;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(int trig, int tick, int period, int mode, int vol, int dec,
                               int div, int a, int s, int o);
      vec_t v;
      v.trig = 1'(trig);  v.tick = 1'(tick);  v.period = 12'(period);
      v.mode = 1'(mode);  v.vol = 4'(vol);    v.dec = 1'(dec);
      v.div = 4'(div);    v.a = 1'(a);        v.s = 1'(s);  v.o = 9'(o);
      return v;
   endfunction

   // Reference LFSR step: right shift, new MSB = bit0 ^ tap
   function automatic logic [14:0] lstep(logic [14:0] x, logic m);
      logic t;
      t = m ? x[6] : x[1];
      return {x[0] ^ t, x[14:1]};
   endfunction

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic drive(int trig, int tick, int period, int mode, int vol, int dec, int div);
      i_trigger       = 1'(trig);
      i_tick_stb      = 1'(tick);
      i_cfg_period    = 12'(period);
      i_cfg_mode      = 1'(mode);
      i_cfg_volume    = 4'(vol);
      i_cfg_decay_en  = 1'(dec);
      i_cfg_decay_div = 4'(div);
   endtask

   task automatic idle_in();
      i_trigger  = 1'b0;
      i_tick_stb = 1'b0;
   endtask

   initial begin
      logic [14:0] model;
      int          bad;
      int          early;
      int          nostb;

      // trig tick per mode vol dec div | active stb out
      tbl[0]  = mk(1, 0, 0, 0, 15, 0, 0, 1, 1, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);    // lfsr 0x4000
      tbl[2]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 480);  // lfsr 0x2000
      tbl[3]  = mk(1, 0, 3, 0, 8,  0, 0, 1, 0, 480);  // trigger on expiry: step + load 3
      tbl[4]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 256);
      tbl[5]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 256);
      tbl[6]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 256);
      tbl[7]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 256);
      tbl[8]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 256);
      tbl[9]  = mk(0, 1, 0, 0, 0,  0, 0, 1, 0, 256);  // tick, decay off: no change
      tbl[10] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 256);
      tbl[11] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 256);
      tbl[12] = mk(1, 1, 0, 1, 3,  1, 1, 1, 1, 256);  // trigger wins over tick
      tbl[13] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 96);
      tbl[14] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 96);   // volume -> 2
      tbl[15] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 64);
      tbl[16] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 64);
      tbl[17] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 64);   // volume -> 1
      tbl[18] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 32);
      tbl[19] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 32);   // volume -> 0
      tbl[20] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 0);
      tbl[21] = mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 0);    // saturates at 0
      tbl[22] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);

      i_rst_n      = 1'b0;
      i_cfg_length = 8'd255;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) cyc();
      chk("rst_active", int'(o_active), 0);
      chk("rst_stb", int'(o_lfsr_stb), 0);
      chk("rst_out", int'(o_output), 0);
      i_rst_n = 1'b1;
      cyc();
      chk("idle_active", int'(o_active), 0);
      chk("idle_stb", int'(o_lfsr_stb), 0);
      chk("idle_lfsr", int'(dut.lfsr_q), 1);

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].trig, tbl[i].tick, tbl[i].period, tbl[i].mode, tbl[i].vol,
               tbl[i].dec, tbl[i].div);
         cyc();
         chk($sformatf("v%0d_active", i), int'(o_active), int'(tbl[i].a));
         chk($sformatf("v%0d_stb", i), int'(o_lfsr_stb), int'(tbl[i].s));
         chk($sformatf("v%0d_out", i), int'(o_output), int'(tbl[i].o));
      end

      // Mid-note reset: outputs drop immediately, stays IDLE afterwards
      drive(1, 0, 0, 0, 15, 0, 0);
      cyc();
      idle_in();
      repeat (3) cyc();
      @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("midrst_active", int'(o_active), 0);
      chk("midrst_stb", int'(o_lfsr_stb), 0);
      chk("midrst_out", int'(o_output), 0);
      chk("midrst_lfsr", int'(dut.lfsr_q), 1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_tick_stb = 1'b1;
      repeat (3) cyc();
      i_tick_stb = 1'b0;
      chk("postrst_active", int'(o_active), 0);
      chk("postrst_stb", int'(o_lfsr_stb), 0);
      chk("postrst_out", int'(o_output), 0);

      // Long mode, period 0: full 32767-step cycle back to 1
      drive(1, 0, 0, 0, 15, 0, 0);
      cyc();
      idle_in();
      chk("long_first", int'(dut.lfsr_q), 1);
      model = 15'd1;
      bad = 0; early = 0; nostb = 0;
      for (int k = 1; k <= 32767; k++) begin
         if (!o_lfsr_stb) nostb++;
         cyc();
         model = lstep(model, 1'b0);
         if (dut.lfsr_q != model) bad++;
         if (k < 32767 && dut.lfsr_q == 15'd1) early++;
         if (k == 1) chk("long_step1", int'(dut.lfsr_q), 16384);
         if (k == 2) chk("long_step2", int'(dut.lfsr_q), 8192);
      end
      chk("long_track_errs", bad, 0);
      chk("long_early_return", early, 0);
      chk("long_stb_gaps", nostb, 0);
      chk("long_return", int'(dut.lfsr_q), 1);

      // Short mode: trigger lands on an expiry, so that step still uses long tap
      drive(1, 0, 0, 1, 15, 0, 0);
      cyc();
      idle_in();
      model = lstep(model, 1'b0);
      chk("short_trig_step", int'(dut.lfsr_q), int'(model));
      bad = 0; nostb = 0;
      for (int k = 0; k < 200; k++) begin
         if (!o_lfsr_stb) nostb++;
         cyc();
         model = lstep(model, 1'b1);
         if (dut.lfsr_q != model) bad++;
      end
      chk("short_track_errs", bad, 0);
      chk("short_stb_gaps", nostb, 0);

      // Decay: volume 15, div 1 -> one step per 2 ticks, holds at 0
      drive(1, 0, 5, 0, 15, 1, 1);
      cyc();
      idle_in();
      chk("decay_start", int'(dut.volume_q), 15);
      bad = 0;
      for (int k = 1; k <= 34; k++) begin
         i_tick_stb = 1'b1;
         cyc();
         i_tick_stb = 1'b0;
         cyc();
         if (int'(dut.volume_q) != ((15 - k / 2) < 0 ? 0 : (15 - k / 2))) bad++;
         if (k == 29) chk("decay_t29", int'(dut.volume_q), 1);
         if (k == 30) chk("decay_t30", int'(dut.volume_q), 0);
      end
      chk("decay_track_errs", bad, 0);
      chk("decay_hold", int'(dut.volume_q), 0);

`ifdef NOISE_LENGTH_COUNTER_EN
      // Length 3: active drops on the 3rd tick; tick with trigger is ignored
      i_cfg_length = 8'd3;
      drive(1, 0, 2, 0, 9, 0, 0);
      cyc();
      for (int k = 1; k <= 3; k++) begin
         drive(0, 1, 2, 0, 9, 0, 0);
         cyc();
         chk($sformatf("len_tick%0d", k), int'(o_active), (k < 3) ? 1 : 0);
      end
      idle_in();
      cyc();
      chk("len_idle_out", int'(o_output), 0);
      chk("len_idle_stb", int'(o_lfsr_stb), 0);
      drive(1, 0, 2, 0, 9, 0, 0);
      cyc();
      drive(0, 1, 2, 0, 9, 0, 0);
      cyc();
      drive(1, 1, 2, 0, 9, 0, 0);
      cyc();
      for (int k = 1; k <= 3; k++) begin
         drive(0, 1, 2, 0, 9, 0, 0);
         cyc();
         chk($sformatf("len_reload_tick%0d", k), int'(o_active), (k < 3) ? 1 : 0);
      end
      idle_in();
`else
      // Without the length counter a note ignores length and runs on
      i_cfg_length = 8'd1;
      drive(1, 0, 2, 0, 9, 0, 0);
      cyc();
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 2, 0, 9, 0, 0);
         cyc();
      end
      idle_in();
      chk("nolen_active", int'(o_active), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
